// File: rtl/axis_video_frame_source.sv
// rtl/axis_video_frame_source.sv - AXI4-Stream test-pattern video frame source
// Streams H_ACTIVE x V_ACTIVE frames in raster order with SOF on tuser[0] and EOL on tlast.
module axis_video_frame_source #(
    parameter int H_ACTIVE         = 800,
    parameter int V_ACTIVE         = 600,
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int AXIS_TUSER_WIDTH = 1,
    parameter int USE_RGB888       = 0,
    parameter int GAP_CYCLES       = 0
) (
    input  logic                        axi_clk,
    input  logic                        axi_rst,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic [15:0]                 solid_color,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        frame_done,
    output logic [15:0]                 frame_count,
    output logic                        busy
);

    if (AXIS_TDATA_WIDTH != 16 && AXIS_TDATA_WIDTH != 24) begin : g_bad_width
        $error("AXIS_TDATA_WIDTH must be 16 or 24");
    end
    if ((USE_RGB888 != 0) != (AXIS_TDATA_WIDTH == 24)) begin : g_bad_rgb888
        $error("USE_RGB888 must equal (AXIS_TDATA_WIDTH == 24)");
    end
    if (H_ACTIVE < 8 || (H_ACTIVE % 8) != 0 || V_ACTIVE < 2) begin : g_bad_geometry
        $error("H_ACTIVE must be >=8 and a multiple of 8, V_ACTIVE must be >=2");
    end

    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = $clog2(V_ACTIVE);
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [GW-1:0]   r_gap_cnt;
    logic [1:0]      r_mode_q;
    logic [15:0]     r_solid_q;
    logic [15:0]     r_frame_count;

    state_t          w_state_nxt;
    logic [XW-1:0]   w_x_nxt;
    logic [YW-1:0]   w_y_nxt;
    logic [GW-1:0]   w_gap_nxt;
    logic [15:0]     w_fc_nxt;
    logic            w_latch;
    logic            w_last_px;

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_gap_nxt   = r_gap_cnt;
        w_fc_nxt    = r_frame_count;
        w_latch     = 1'b0;
        w_last_px   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_STREAM;
                    w_latch     = 1'b1;
                end
            end
            ST_STREAM: begin
                if (m_axis_tready) begin
                    if (r_x == X_LAST) begin
                        w_x_nxt = '0;
                        if (r_y == Y_LAST) begin
                            w_y_nxt   = '0;
                            w_last_px = 1'b1;
                            w_fc_nxt  = r_frame_count + 16'd1;
                            // Frame boundary: the only point where enable and pattern inputs are resampled
                            if (GAP_CYCLES > 0) begin
                                w_state_nxt = ST_GAP;
                                w_gap_nxt   = '0;
                            end else if (enable) begin
                                w_latch = 1'b1;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_y_nxt = r_y + 1'b1;
                        end
                    end else begin
                        w_x_nxt = r_x + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (enable) begin
                        w_state_nxt = ST_STREAM;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_gap_cnt     <= '0;
            r_mode_q      <= 2'd0;
            r_solid_q     <= 16'd0;
            r_frame_count <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_gap_cnt     <= w_gap_nxt;
            r_frame_count <= w_fc_nxt;
            if (w_latch) begin
                r_mode_q  <= mode;
                r_solid_q <= solid_color;
            end
        end
    end

    logic [15:0] w_x16;
    logic [15:0] w_y16;
    logic [2:0]  w_bar;
    logic [15:0] w_rgb565;
    logic [AXIS_TDATA_WIDTH-1:0] w_pix;

    assign w_x16 = 16'(r_x);
    assign w_y16 = 16'(r_y);
    assign w_bar = 3'(32'(r_x) / BAR_W);

    always_comb begin
        w_rgb565 = 16'h0000;
        case (r_mode_q)
            2'd0: begin
                case (w_bar)
                    3'd0:    w_rgb565 = 16'hFFFF;
                    3'd1:    w_rgb565 = 16'hFFE0;
                    3'd2:    w_rgb565 = 16'h07FF;
                    3'd3:    w_rgb565 = 16'h07E0;
                    3'd4:    w_rgb565 = 16'hF81F;
                    3'd5:    w_rgb565 = 16'hF800;
                    3'd6:    w_rgb565 = 16'h001F;
                    default: w_rgb565 = 16'h0000;
                endcase
            end
            2'd1:    w_rgb565 = (w_x16[5] ^ w_y16[5]) ? 16'h0000 : 16'hFFFF;
            2'd2:    w_rgb565 = {w_x16[9:5], w_y16[9:4], r_frame_count[4:0]};
            default: w_rgb565 = r_solid_q;
        endcase
    end

    // RGB888 widens each channel by replicating its MSBs so full-scale stays full-scale
    if (AXIS_TDATA_WIDTH == 24) begin : g_rgb888
        assign w_pix = {w_rgb565[15:11], w_rgb565[15:13],
                        w_rgb565[10:5],  w_rgb565[10:9],
                        w_rgb565[4:0],   w_rgb565[4:2]};
    end else begin : g_rgb565
        assign w_pix = AXIS_TDATA_WIDTH'(w_rgb565);
    end

    always_comb begin
        m_axis_tuser    = '0;
        m_axis_tuser[0] = m_axis_tvalid && (r_x == '0) && (r_y == '0);
    end

    assign m_axis_tvalid = (r_state == ST_STREAM);
    assign m_axis_tdata  = m_axis_tvalid ? w_pix : '0;
    assign m_axis_tlast  = m_axis_tvalid && (r_x == X_LAST);
    assign frame_done    = w_last_px;
    assign frame_count   = r_frame_count;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axis_video_frame_source.sv
// tb/tb_axis_video_frame_source.sv - scoreboard bench for axis_video_frame_source
module tb_axis_video_frame_source;
    localparam int H = 8;
    localparam int V = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, tready, tlast, tvalid, fdone, busy;
    logic [1:0]  mode;
    logic [15:0] solid, tdata, fcount;
    logic [0:0]  tuser;

    logic        g_rst, g_en, g_tready, g_tlast, g_tvalid, g_fdone, g_busy;
    logic [1:0]  g_mode;
    logic [15:0] g_solid, g_tdata, g_fcount;
    logic [0:0]  g_tuser;

    axis_video_frame_source #(.H_ACTIVE(H), .V_ACTIVE(V), .AXIS_TDATA_WIDTH(16),
        .AXIS_TUSER_WIDTH(1), .USE_RGB888(0), .GAP_CYCLES(0)) dut (
        .axi_clk(clk), .axi_rst(rst), .enable(en), .mode(mode), .solid_color(solid),
        .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .frame_done(fdone),
        .frame_count(fcount), .busy(busy));

    axis_video_frame_source #(.H_ACTIVE(H), .V_ACTIVE(V), .AXIS_TDATA_WIDTH(16),
        .AXIS_TUSER_WIDTH(1), .USE_RGB888(0), .GAP_CYCLES(3)) dut_g (
        .axi_clk(clk), .axi_rst(g_rst), .enable(g_en), .mode(g_mode), .solid_color(g_solid),
        .m_axis_tdata(g_tdata), .m_axis_tuser(g_tuser), .m_axis_tlast(g_tlast),
        .m_axis_tvalid(g_tvalid), .m_axis_tready(g_tready), .frame_done(g_fdone),
        .frame_count(g_fcount), .busy(g_busy));

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        last;
        logic        done;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       g_exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          acc = 0;
    int          g_acc = 0;
    logic [15:0] fc_model = 16'd0;
    logic [15:0] g_fc_model = 16'd0;
    bit          rand_ready = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] ref_pixel(int m, logic [15:0] s, int x, int y, int fc);
        logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                  16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        case (m)
            0:       return bars[x / (H / 8)];
            1:       return (((x / 32) % 2) != ((y / 32) % 2)) ? 16'h0000 : 16'hFFFF;
            2:       return 16'(((x / 32) % 32) * 2048 + ((y / 16) % 64) * 32 + (fc % 32));
            default: return s;
        endcase
    endfunction

    task automatic push_frame(bit g, int m, logic [15:0] s, int fc);
        beat_t b;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                b.data = ref_pixel(m, s, x, y, fc);
                b.sof  = (x == 0 && y == 0);
                b.last = (x == H - 1);
                b.done = (x == H - 1 && y == V - 1);
                if (g) g_exp_q.push_back(b);
                else   exp_q.push_back(b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(bit g, int target);
        int n = 0;
        while (((g ? g_acc : acc) < target) && n < 2000) begin
            tick();
            n++;
        end
        chk("wait_acc_reached", ((g ? g_acc : acc) >= target), 1);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) tready = 1'($urandom_range(0, 1));
    end

    bit          stalled = 1'b0;
    logic [17:0] held;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_tvalid_kept", tvalid, 1);
                chk("stall_hold", {tdata, tuser, tlast}, held);
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got tdata %0h expected no beat", tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", tdata, e.data);
                    chk("tuser", tuser, e.sof);
                    chk("tlast", tlast, e.last);
                    chk("frame_done", fdone, e.done);
                end
                acc++;
            end else begin
                chk("frame_done_no_accept", fdone, 0);
            end
            stalled = tvalid && !tready;
            held    = {tdata, tuser, tlast};
        end
    end

    int g_idle = 0;
    bit g_seen_end = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (!g_rst) begin
            if (g_tvalid && g_tready) begin
                if (g_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL g_unexpected_beat: got tdata %0h expected no beat", g_tdata);
                end else begin
                    e = g_exp_q.pop_front();
                    chk("g_tdata", g_tdata, e.data);
                    chk("g_tuser", g_tuser, e.sof);
                    chk("g_tlast", g_tlast, e.last);
                    chk("g_frame_done", g_fdone, e.done);
                    if (e.sof && g_seen_end) chk("g_gap_cycles", g_idle, 3);
                    if (e.done) begin
                        g_seen_end = 1'b1;
                        g_idle     = 0;
                    end
                end
                g_acc++;
            end else if (!g_tvalid) begin
                g_idle++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst = 1'b1; en = 1'b0; mode = 2'd0; solid = 16'd0; tready = 1'b1;
        g_rst = 1'b1; g_en = 1'b0; g_mode = 2'd0; g_solid = 16'd0; g_tready = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_frame_done", fdone, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_count", fcount, 0);
        rst = 1'b0;
        g_rst = 1'b0;
        tick();

        // colour bars, latency and single-frame completion
        push_frame(0, 0, 16'd0, int'(fc_model)); fc_model++;
        mode = 2'd0; en = 1'b1;
        chk("s1_tvalid_before", tvalid, 0);
        tick();
        chk("s1_latency", tvalid, 1);
        chk("s1_busy", busy, 1);
        en = 1'b0;
        wait_acc(0, 32);
        chk("s1_frame_count", fcount, fc_model);
        chk("s1_idle_tvalid", tvalid, 0);
        chk("s1_idle_busy", busy, 0);
        chk("s1_queue_empty", exp_q.size(), 0);

        // solid colour under random backpressure, two frames; solid change mid-frame must not leak
        mode = 2'd3; solid = 16'h1234; rand_ready = 1'b1;
        push_frame(0, 3, 16'h1234, int'(fc_model)); fc_model++;
        push_frame(0, 3, 16'h1234, int'(fc_model)); fc_model++;
        base = acc; en = 1'b1;
        wait_acc(0, base + 33);
        en = 1'b0;
        wait_acc(0, base + 40);
        solid = 16'hABCD;
        wait_acc(0, base + 64);
        rand_ready = 1'b0; tready = 1'b1;
        chk("s2_frame_count", fcount, fc_model);
        chk("s2_idle_tvalid", tvalid, 0);
        chk("s2_queue_empty", exp_q.size(), 0);

        // enable dropped at beat 10: frame still completes
        mode = 2'd0;
        push_frame(0, 0, 16'd0, int'(fc_model)); fc_model++;
        base = acc; en = 1'b1;
        wait_acc(0, base + 10);
        en = 1'b0;
        wait_acc(0, base + 32);
        chk("s3_frame_count", fcount, fc_model);
        chk("s3_tvalid", tvalid, 0);
        chk("s3_busy", busy, 0);
        repeat (3) tick();
        chk("s3_stays_idle", tvalid, 0);

        // mode change mid-frame applies only to the following frame
        mode = 2'd0;
        push_frame(0, 0, 16'd0, int'(fc_model)); fc_model++;
        push_frame(0, 1, 16'd0, int'(fc_model)); fc_model++;
        base = acc; en = 1'b1;
        wait_acc(0, base + 5);
        mode = 2'd1;
        wait_acc(0, base + 33);
        en = 1'b0;
        wait_acc(0, base + 64);
        chk("s4_frame_count", fcount, fc_model);

        // gradient: blue channel carries frame_count
        mode = 2'd2;
        push_frame(0, 2, 16'd0, int'(fc_model)); fc_model++;
        base = acc; en = 1'b1;
        wait_acc(0, base + 1);
        en = 1'b0;
        wait_acc(0, base + 32);
        chk("s4b_frame_count", fcount, fc_model);

        // reset mid-frame at beat 13
        mode = 2'd0;
        push_frame(0, 0, 16'd0, int'(fc_model)); fc_model++;
        base = acc; en = 1'b1;
        wait_acc(0, base + 13);
        rst = 1'b1;
        tick();
        chk("s5_rst_tvalid", tvalid, 0);
        chk("s5_rst_frame_count", fcount, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_tdata", tdata, 0);
        exp_q.delete();
        fc_model = 16'd0;
        push_frame(0, 0, 16'd0, int'(fc_model)); fc_model++;
        rst = 1'b0;
        base = acc;
        wait_acc(0, base + 1);
        en = 1'b0;
        wait_acc(0, base + 32);
        chk("s5_restart_frame_count", fcount, fc_model);
        chk("s5_queue_empty", exp_q.size(), 0);

        // gap instance: 3 idle cycles between frames, frame_count wrap from 0xFFFF
        dut_g.r_frame_count = 16'hFFFF;
        g_fc_model = 16'hFFFF;
        push_frame(1, 2, 16'd0, int'(g_fc_model)); g_fc_model++;
        push_frame(1, 2, 16'd0, int'(g_fc_model)); g_fc_model++;
        g_mode = 2'd2; g_en = 1'b1;
        wait_acc(1, 32);
        chk("s6_wrap", g_fcount, 16'h0000);
        chk("s6_gap_busy", g_busy, 1);
        chk("s6_gap_tvalid", g_tvalid, 0);
        wait_acc(1, 33);
        g_en = 1'b0;
        wait_acc(1, 64);
        chk("s6_frame_count", g_fcount, g_fc_model);
        chk("s6_end_gap_busy", g_busy, 1);
        repeat (3) tick();
        chk("s6_end_idle_busy", g_busy, 0);
        chk("s6_end_tvalid", g_tvalid, 0);
        chk("s6_queue_empty", g_exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
